// File: rtl/mem_bus_pkg.sv
// Shared definitions for the Select/Mode memory bus responder.
// Holds the FSM state encoding, the access mode codes and the width of the statistics counters.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mem_bus_if.sv
// Select/Mode memory bus between the opcode executor (master) and the responder (slave).
interface mem_bus_if #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 2
);
   logic         select;
   logic         mode;
   logic [M-1:0] addr;
   logic [N-1:0] data_in;
   logic [N-1:0] data_out;
   logic         ack;
   logic         busy;

   modport master (
      output select, mode, addr, data_in,
      input  data_out, ack, busy
   );

   modport slave (
      input  select, mode, addr, data_in,
      output data_out, ack, busy
   );
endinterface

// File: rtl/mem_bus_array.sv
// 2**M x N register array with synchronous write, registered read port and async clear.
module mem_bus_array #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic         rd_en,
   input  logic [M-1:0] addr,
   input  logic [N-1:0] wdata,
   output logic [N-1:0] rdata
);
   localparam int unsigned DEPTH = 1 << M;

   logic [N-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rdata <= '0;
      end else begin
         if (wr_en) mem_q[addr] <= wdata;
         if (rd_en) rdata <= mem_q[addr];
      end
   end
endmodule

// File: rtl/mem_bus_responder.sv
// Target end of the executor memory bus: one access per Select assertion, WAIT cycles, then Ack.
// Optional MEM_BUS_STATS_EN adds saturating read/write access counters.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned M    = 2,
   parameter int unsigned WAIT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_if.slave          bus
`ifdef MEM_BUS_STATS_EN
   ,
   output logic [STAT_W-1:0] read_count,
   output logic [STAT_W-1:0] write_count
`endif
);
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned WAIT_LOAD = (WAIT == 0) ? 0 : WAIT - 1;

   state_t         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           mode_q;
   logic [M-1:0]   addr_q;
   logic [N-1:0]   data_q;
   logic           latch_c;
   logic           do_op_c;
   logic           op_mode_c;
   logic [M-1:0]   op_addr_c;
   logic [N-1:0]   op_data_c;
   logic           wr_en_c;
   logic           rd_en_c;

   // With WAIT = 0 the access happens on the accepting edge, so it must use the live bus values.
   assign op_mode_c = (state_q == ST_IDLE) ? bus.mode    : mode_q;
   assign op_addr_c = (state_q == ST_IDLE) ? bus.addr    : addr_q;
   assign op_data_c = (state_q == ST_IDLE) ? bus.data_in : data_q;
   assign wr_en_c   = do_op_c && (op_mode_c == MODE_WRITE);
   assign rd_en_c   = do_op_c && (op_mode_c == MODE_READ);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      latch_c = 1'b0;
      do_op_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.select) begin
               latch_c = 1'b1;
               if (WAIT == 0) begin
                  state_d = ST_ACK;
                  do_op_c = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(WAIT_LOAD);
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               cnt_d   = '0;
               state_d = ST_ACK;
               do_op_c = 1'b1;
            end
         end
         ST_ACK: begin
            state_d = bus.select ? ST_RELEASE : ST_IDLE;
         end
         ST_RELEASE: begin
            if (!bus.select) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mode_q   <= MODE_READ;
         addr_q   <= '0;
         data_q   <= '0;
         bus.ack  <= 1'b0;
         bus.busy <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bus.ack  <= (state_d == ST_ACK);
         bus.busy <= (state_d != ST_IDLE);
         if (latch_c) begin
            mode_q <= bus.mode;
            addr_q <= bus.addr;
            data_q <= bus.data_in;
         end
      end
   end

   mem_bus_array #(.N(N), .M(M)) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en_c),
      .rd_en (rd_en_c),
      .addr  (op_addr_c),
      .wdata (op_data_c),
      .rdata (bus.data_out)
   );

`ifdef MEM_BUS_STATS_EN
   // Counters advance on the same edge the access is performed and stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_count  <= '0;
         write_count <= '0;
      end else begin
         if (rd_en_c && (read_count != '1))  read_count  <= read_count + STAT_W'(1);
         if (wr_en_c && (write_count != '1)) write_count <= write_count + STAT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder: WAIT = 1 instance plus a WAIT = 0 instance.
module tb_mem_bus_responder;
   import mem_bus_pkg::*;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mem_bus_if #(.N(8), .M(2)) bus0 ();
   mem_bus_if #(.N(8), .M(2)) bus1 ();

`ifdef MEM_BUS_STATS_EN
   logic [STAT_W-1:0] rc0, wc0, rc1, wc1;
`endif

   mem_bus_responder #(.N(8), .M(2), .WAIT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
`ifdef MEM_BUS_STATS_EN
      , .read_count (rc0), .write_count (wc0)
`endif
   );

   mem_bus_responder #(.N(8), .M(2), .WAIT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
`ifdef MEM_BUS_STATS_EN
      , .read_count (rc1), .write_count (wc1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic ack_of(input int which);
      return (which == 0) ? bus0.ack : bus1.ack;
   endfunction

   task automatic drive(input int which, input logic sel, input logic m,
                        input logic [1:0] a, input logic [7:0] d);
      if (which == 0) begin
         bus0.select = sel; bus0.mode = m; bus0.addr = a; bus0.data_in = d;
      end else begin
         bus1.select = sel; bus1.mode = m; bus1.addr = a; bus1.data_in = d;
      end
   endtask

   // One full handshake; lat = negedges from request to the Ack cycle, -1 on timeout.
   task automatic xact(input int which, input logic m, input logic [1:0] a,
                       input logic [7:0] d, output int lat);
      @(negedge clk);
      drive(which, 1'b1, m, a, d);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack_of(which)) begin
            lat = i;
            break;
         end
      end
      drive(which, 1'b0, m, a, d);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int acks;

      rst_n = 1'b0;
      drive(0, 1'b0, MODE_READ, 2'd0, 8'h00);
      drive(1, 1'b0, MODE_READ, 2'd0, 8'h00);
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(bus1.ack), 32'd0);
      check("rst_busy", 32'(bus1.busy), 32'd0);
      check("rst_dout", 32'(bus1.data_out), 32'h00);
      rst_n = 1'b1;

      // Reset in the middle of WAIT after a readable A5 in addr 1
      xact(1, MODE_WRITE, 2'd1, 8'hA5, lat);
      check("wr_a5_lat", 32'(lat), 32'd2);
      xact(1, MODE_READ, 2'd1, 8'h00, lat);
      check("rd_a5_dout", 32'(bus1.data_out), 32'hA5);
      @(negedge clk);
      drive(1, 1'b1, MODE_READ, 2'd1, 8'h00);
      @(negedge clk);
      check("busy_in_wait", 32'(bus1.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      drive(1, 1'b0, MODE_READ, 2'd1, 8'h00);
      #1;
      check("async_rst_ack", 32'(bus1.ack), 32'd0);
      check("async_rst_busy", 32'(bus1.busy), 32'd0);
      check("async_rst_dout", 32'(bus1.data_out), 32'h00);
      acks = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus1.ack) acks++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus1.ack) acks++;
      end
      check("no_ack_after_rst", 32'(acks), 32'd0);
      xact(1, MODE_READ, 2'd1, 8'h00, lat);
      check("rd_after_rst", 32'(bus1.data_out), 32'h00);

      // Write then read with one wait cycle; DataOut held and untouched by writes
      xact(1, MODE_WRITE, 2'd2, 8'h3C, lat);
      check("wr_3c_lat", 32'(lat), 32'd2);
      xact(1, MODE_READ, 2'd2, 8'h00, lat);
      check("rd_3c_lat", 32'(lat), 32'd2);
      check("rd_3c_dout", 32'(bus1.data_out), 32'h3C);
      repeat (3) @(negedge clk);
      check("dout_held", 32'(bus1.data_out), 32'h3C);
      xact(1, MODE_WRITE, 2'd0, 8'h5A, lat);
      check("dout_after_wr", 32'(bus1.data_out), 32'h3C);

      // Held Select: one Ack, sits in RELEASE, no second access with new data
      @(negedge clk);
      drive(1, 1'b1, MODE_WRITE, 2'd3, 8'h11);
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus1.ack) begin
            acks++;
            bus1.data_in = 8'h22;
         end
      end
      check("held_one_ack", 32'(acks), 32'd1);
      check("held_busy", 32'(bus1.busy), 32'd1);
      drive(1, 1'b0, MODE_READ, 2'd3, 8'h00);
      @(negedge clk);
      check("held_release_idle", 32'(bus1.busy), 32'd0);
      xact(1, MODE_READ, 2'd3, 8'h00, lat);
      check("held_word", 32'(bus1.data_out), 32'h11);

      // Inputs change and Select drops right after acceptance
      @(negedge clk);
      drive(1, 1'b1, MODE_WRITE, 2'd1, 8'h77);
      @(negedge clk);
      drive(1, 1'b0, MODE_WRITE, 2'd0, 8'hFF);
      @(negedge clk);
      check("early_drop_ack", 32'(bus1.ack), 32'd1);
      @(negedge clk);
      check("early_drop_idle", 32'(bus1.busy), 32'd0);
      xact(1, MODE_READ, 2'd1, 8'h00, lat);
      check("latched_addr_data", 32'(bus1.data_out), 32'h77);
      xact(1, MODE_READ, 2'd0, 8'h00, lat);
      check("addr0_unchanged", 32'(bus1.data_out), 32'h5A);

      // WAIT = 0 instance
      @(negedge clk);
      drive(0, 1'b1, MODE_READ, 2'd0, 8'h00);
      @(negedge clk);
      check("w0_ack", 32'(bus0.ack), 32'd1);
      check("w0_busy", 32'(bus0.busy), 32'd1);
      drive(0, 1'b0, MODE_READ, 2'd0, 8'h00);
      @(negedge clk);
      check("w0_ack_off", 32'(bus0.ack), 32'd0);
      check("w0_busy_off", 32'(bus0.busy), 32'd0);
      xact(0, MODE_WRITE, 2'd3, 8'h9C, lat);
      check("w0_wr_lat", 32'(lat), 32'd1);
      xact(0, MODE_READ, 2'd3, 8'h00, lat);
      check("w0_rd_dout", 32'(bus0.data_out), 32'h9C);

`ifdef MEM_BUS_STATS_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      xact(1, MODE_WRITE, 2'd0, 8'h01, lat);
      xact(1, MODE_WRITE, 2'd1, 8'h02, lat);
      xact(1, MODE_READ,  2'd0, 8'h00, lat);
      xact(1, MODE_WRITE, 2'd2, 8'h03, lat);
      xact(1, MODE_READ,  2'd1, 8'h00, lat);
      check("stat_writes", 32'(wc1), 32'd3);
      check("stat_reads", 32'(rc1), 32'd2);
      @(negedge clk);
      force dut1.write_count = 16'hFFFF;
      @(negedge clk);
      release dut1.write_count;
      xact(1, MODE_WRITE, 2'd3, 8'h04, lat);
      check("stat_wr_sat", 32'(wc1), 32'h0000FFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
